// File: rtl/add_seq32_pkg.sv
// add_seq32_pkg
// Shared encodings for the nibble-serial add/subtract block and its slice.
//   state_e : FSM state encodings (IDLE, RUN, DONE)
//   op_e    : operation select encodings (ADD, SUB)
//   NIB_W   : width of the adder slice in bits
package add_seq32_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } op_e;

endpackage

// File: rtl/cla4.sv
// cla4
// Combinational 4-bit carry look-ahead adder slice.
// Ports:
//   a, b : 4-bit addends
//   ci   : carry in
//   s    : 4-bit sum
//   co   : carry out of bit 3
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // All carries are flattened from generate/propagate terms, so no carry
  // ripples through the slice.
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[3:0];
  assign co = c[4];

endmodule

// File: rtl/add_seq32.sv
// add_seq32
// Nibble-serial WIDTH-bit add/subtract built around a single cla4 slice.
// One nibble is processed per clock, LSB nibble first, so an operation
// takes WIDTH/4 RUN cycles followed by a one-cycle DONE.
// Ports:
//   clk    : clock, all state changes on its rising edge
//   reset  : synchronous active-high reset
//   start  : request pulse, only honoured in IDLE or DONE
//   op     : 0 = a+b, 1 = a-b (sampled with start)
//   a, b   : operands (sampled with start)
//   busy   : high while in RUN
//   done   : one-cycle pulse, result/co/ovf valid
//   result : sum or difference
//   co     : carry out of MSB (subtract: 1 = no borrow)
//   ovf    : two's-complement signed overflow
//
// state | meaning
// IDLE  | waiting for start, outputs hold last result
// RUN   | one nibble per cycle through the slice
// DONE  | done pulse; start here launches the next operation
module add_seq32
  import add_seq32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / NIB_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_e           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             snap_a;
  logic             snap_b;
  logic [3:0]       sum_nib;
  logic             slice_co;
  logic [WIDTH-1:0] b_eff;
  logic             is_sub;
  logic             last_nib;
  logic             ovf_next;

  // Subtraction is a + ~b + 1: invert b here and seed the carry with 1.
  assign is_sub   = (op == SUB);
  assign b_eff    = is_sub ? ~b : b;
  assign last_nib = (cnt == LAST_CNT);
  // The final sum nibble's top bit becomes result[WIDTH-1].
  assign ovf_next = (snap_a == snap_b) && (sum_nib[3] != snap_a);

  cla4 u_cla4 (
    .a  (a_reg[3:0]),
    .b  (b_reg[3:0]),
    .ci (carry),
    .s  (sum_nib),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      snap_a <= 1'b0;
      snap_b <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            a_reg  <= a;
            b_reg  <= b_eff;
            carry  <= is_sub;
            cnt    <= '0;
            snap_a <= a[WIDTH-1];
            snap_b <= b_eff[WIDTH-1];
          end
        end

        RUN: begin
          carry  <= slice_co;
          a_reg  <= {4'b0000, a_reg[WIDTH-1:4]};
          b_reg  <= {4'b0000, b_reg[WIDTH-1:4]};
          result <= {sum_nib, result[WIDTH-1:4]};
          if (last_nib) begin
            // Counter parks at N-1 instead of wrapping.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            co    <= slice_co;
            ovf   <= ovf_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            a_reg  <= a;
            b_reg  <= b_eff;
            carry  <= is_sub;
            cnt    <= '0;
            snap_a <= a[WIDTH-1];
            snap_b <= b_eff[WIDTH-1];
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq32.sv
module tb_add_seq32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        co;
  logic        ovf;

  int n_assert = 0;
  int n_fail   = 0;

  add_seq32 #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .co     (co),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one operation from IDLE, wait for done, check latency,
  // result flags and that done drops after one cycle.
  task automatic run_op(input string tag, input logic op_i, input logic [31:0] a_i,
                        input logic [31:0] b_i, input logic [31:0] exp_r,
                        input logic exp_co, input logic exp_ovf);
    int lat;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(negedge clk);                       // start edge has passed
    start = 1'b0; op = 1'b0; a = '0; b = '0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    seen = 0;
    lat  = 0;
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        lat  = j;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_result"}, result, exp_r);
    chk({tag, "_co"}, 32'(co), 32'(exp_co));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    int pulses;
    int t1;
    int t2;
    bit got1;
    bit got2;

    reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'h1; b = 32'h1;
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy), 32'd0);
    chk("rst_done",   32'(done), 32'd0);
    chk("rst_result", result,    32'd0);
    chk("rst_co",     32'(co),   32'd0);
    chk("rst_ovf",    32'(ovf),  32'd0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_discarded", 32'(busy), 32'd0);

    run_op("add_wrap",  1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add_ovf",   1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_5_7",   1'b1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7_5",   1'b1, 32'd7,         32'd5,         32'h0000_0002, 1'b1, 1'b0);
    run_op("sub_min_1", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Second start during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h1111_1111;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    @(negedge clk);
    chk("ign_busy", 32'(busy), 32'd1);
    start = 1'b0; op = 1'b1; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    pulses = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        chk("ign_result", result, 32'h2345_6789);
        chk("ign_co",  32'(co),  32'd0);
        chk("ign_ovf", 32'(ovf), 32'd0);
      end
    end
    chk("ign_pulses", 32'(pulses), 32'd1);

    // Back-to-back: start held through DONE.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h0000_000F; b = 32'h0000_0001;
    got1 = 0; got2 = 0; t1 = 0; t2 = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done && !got1) begin
        got1 = 1; t1 = j;
        chk("b2b_r1", result, 32'h0000_0010);
        chk("b2b_co1", 32'(co), 32'd0);
        op = 1'b1; a = 32'h0000_0010; b = 32'h0000_0020;
      end else if (done && got1 && !got2) begin
        got2 = 1; t2 = j;
        chk("b2b_r2", result, 32'hFFFF_FFF0);
        chk("b2b_co2", 32'(co), 32'd0);
        chk("b2b_ovf2", 32'(ovf), 32'd0);
        start = 1'b0;
        break;
      end else if (got1 && j == t1 + 1) begin
        chk("b2b_rerun_busy", 32'(busy), 32'd1);
      end
    end
    start = 1'b0;
    chk("b2b_two_pulses", 32'({got1, got2}), 32'd3);
    chk("b2b_gap", 32'(t2 - t1), 32'd9);
    repeat (2) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    start = 1'b1; op = 1'b0; a = 32'h1111_1111; b = 32'h2222_2222;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy",   32'(busy), 32'd0);
    chk("abort_done",   32'(done), 32'd0);
    chk("abort_result", result,    32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    run_op("post_rst", 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
